// File: rtl/booth_divide_fsmd.sv
// Sequential signed 16/8 divider using a restoring shift-subtract FSMD.
// It shares the enable/data-valid handshake of the Booth multiplier so a product can be divided back by one of its factors.
module booth_divide_fsmd (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic [15:0] dividend_i,
  input  logic [7:0]  divisor_i,
  output logic        data_valid_o,
  output logic        busy_o,
  output logic        error_o,
  output logic [7:0]  quotient_o,
  output logic [7:0]  remainder_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_sign_q;
  logic        r_sign_r;
  logic [15:0] r_quo;
  logic [7:0]  r_dvs;
  logic [8:0]  r_prem;
  logic [3:0]  r_count;

  logic [15:0] w_dvd_mag;
  logic [7:0]  w_dvs_mag;
  logic [8:0]  w_shift;
  logic [9:0]  w_trial;
  logic        w_q_fits;
  logic [7:0]  w_q_signed;
  logic [7:0]  w_q_sat;
  logic [7:0]  w_r_signed;

  // Unsigned magnitudes: 0x8000 and 0x80 negate to themselves, which is exactly the magnitude we want.
  assign w_dvd_mag = dividend_i[15] ? (~dividend_i + 16'd1) : dividend_i;
  assign w_dvs_mag = divisor_i[7]   ? (~divisor_i + 8'd1)   : divisor_i;

  assign w_shift = {r_prem[7:0], r_quo[15]};
  assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs};

  assign w_q_fits   = (r_quo <= 16'd127) || ((r_quo == 16'd128) && r_sign_q);
  assign w_q_signed = r_sign_q ? (~r_quo[7:0] + 8'd1) : r_quo[7:0];
  assign w_q_sat    = r_sign_q ? 8'h80 : 8'h7F;
  assign w_r_signed = r_sign_r ? (~r_prem[7:0] + 8'd1) : r_prem[7:0];

  // NOTE: every register here is updated with non-blocking assignments so all reads see pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_sign_q     <= 1'b0;
      r_sign_r     <= 1'b0;
      r_quo        <= '0;
      r_dvs        <= '0;
      r_prem       <= '0;
      r_count      <= '0;
      data_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      error_o      <= 1'b0;
      quotient_o   <= '0;
      remainder_o  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable_i) begin
            r_sign_q <= dividend_i[15] ^ divisor_i[7];
            r_sign_r <= dividend_i[15];
            r_quo    <= w_dvd_mag;
            r_dvs    <= w_dvs_mag;
            r_prem   <= '0;
            r_count  <= '0;
            busy_o   <= 1'b1;
            if (divisor_i == 8'h00) begin
              error_o      <= 1'b1;
              quotient_o   <= '0;
              remainder_o  <= '0;
              data_valid_o <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          // The quotient bits shift into the vacated LSBs of the dividend register.
          if (!w_trial[9]) begin
            r_prem <= w_trial[8:0];
            r_quo  <= {r_quo[14:0], 1'b1};
          end else begin
            r_prem <= w_shift;
            r_quo  <= {r_quo[14:0], 1'b0};
          end
          r_count <= r_count + 4'd1;
          if (r_count == 4'd15) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          error_o      <= ~w_q_fits;
          quotient_o   <= w_q_fits ? w_q_signed : w_q_sat;
          remainder_o  <= w_r_signed;
          data_valid_o <= 1'b1;
          r_state      <= S_DONE;
        end

        S_DONE: begin
          data_valid_o <= 1'b0;
          busy_o       <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divide_fsmd.sv
// Directed self-checking bench for booth_divide_fsmd.
// Expected values are hand-computed signed divisions (truncation toward zero, remainder takes the dividend's sign).
module tb_booth_divide_fsmd;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [15:0] dividend_i;
  logic [7:0]  divisor_i;
  logic        data_valid_o;
  logic        busy_o;
  logic        error_o;
  logic [7:0]  quotient_o;
  logic [7:0]  remainder_o;

  int n_checks = 0;
  int n_errors = 0;

  booth_divide_fsmd dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .data_valid_o (data_valid_o),
    .busy_o       (busy_o),
    .error_o      (error_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Starts one operation, measures the edge on which data_valid_o rises (E0 = capture edge) and checks results.
  task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input logic [7:0] exp_q, input logic [7:0] exp_r,
                         input logic exp_err, input int exp_edge);
    int edge_idx;
    dividend_i = a;
    divisor_i  = b;
    enable_i   = 1'b1;
    @(posedge clk_i);
    #1;
    enable_i   = 1'b0;
    dividend_i = 16'h5A5A;
    divisor_i  = 8'h33;
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
    edge_idx = 0;
    while (!data_valid_o && edge_idx < 40) begin
      @(posedge clk_i);
      #1;
      edge_idx++;
    end
    check({tag, "_valid_edge"}, edge_idx, exp_edge);
    check({tag, "_quotient"}, {24'd0, quotient_o}, {24'd0, exp_q});
    check({tag, "_remainder"}, {24'd0, remainder_o}, {24'd0, exp_r});
    check({tag, "_error"}, {31'd0, error_o}, {31'd0, exp_err});
    @(posedge clk_i);
    #1;
    check({tag, "_valid_drop"}, {31'd0, data_valid_o}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first_edge;
    int second_edge;

    reset_i    = 1'b1;
    enable_i   = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    #1;
    check("reset_valid", {31'd0, data_valid_o}, 32'd0);
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_error", {31'd0, error_o}, 32'd0);
    check("reset_q", {24'd0, quotient_o}, 32'd0);
    check("reset_r", {24'd0, remainder_o}, 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // -11979 / 121 = -99 exactly
    run_div("inverse", 16'hD135, 8'h79, 8'h9D, 8'h00, 1'b0, 17);
    // 100 / -7, -100 / 7, -100 / -7
    run_div("pos_neg", 16'h0064, 8'hF9, 8'hF2, 8'h02, 1'b0, 17);
    run_div("neg_pos", 16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 17);
    run_div("neg_neg", 16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 17);
    // -128 / -128 = 1 exercises the |divisor| = 128 path
    run_div("div128", 16'hFF80, 8'h80, 8'h01, 8'h00, 1'b0, 17);
    // -16384 / -128 = +128 does not fit a signed byte
    run_div("div128_ovf", 16'hC000, 8'h80, 8'h7F, 8'h00, 1'b1, 17);
    // -16384 / 127 = -129 r -1: overflow saturates to 0x80
    run_div("neg_ovf", 16'hC000, 8'h7F, 8'h80, 8'hFF, 1'b1, 17);
    // -128 / 1 = -128 is the one magnitude-128 result that fits
    run_div("min_fit", 16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 17);
    run_div("min_div_m1", 16'h8000, 8'hFF, 8'h7F, 8'h00, 1'b1, 17);
    run_div("pos_ovf", 16'h03E8, 8'h02, 8'h7F, 8'h00, 1'b1, 17);
    run_div("div_zero", 16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 0);

    // enable pulsed mid-CALC must be ignored
    dividend_i = 16'h0064;
    divisor_i  = 8'hF9;
    enable_i   = 1'b1;
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    enable_i = 1'b1;
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (data_valid_o) pulses++;
      @(posedge clk_i);
      #1;
    end
    check("calc_enable_pulses", pulses, 1);
    check("calc_enable_q", {24'd0, quotient_o}, 32'h0000_00F2);

    // Asynchronous reset at iteration 8 clears outputs at once and suppresses the valid pulse
    dividend_i = 16'hFF9C;
    divisor_i  = 8'h07;
    enable_i   = 1'b1;
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_valid", {31'd0, data_valid_o}, 32'd0);
    check("abort_error", {31'd0, error_o}, 32'd0);
    check("abort_q", {24'd0, quotient_o}, 32'd0);
    check("abort_r", {24'd0, remainder_o}, 32'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 25; i++) begin
      if (data_valid_o) pulses++;
      @(posedge clk_i);
      #1;
    end
    check("abort_no_valid", pulses, 0);
    run_div("after_abort", 16'hD135, 8'h79, 8'h9D, 8'h00, 1'b0, 17);

    // enable held high: consecutive operations 19 cycles apart
    dividend_i  = 16'hFF9C;
    divisor_i   = 8'hF9;
    enable_i    = 1'b1;
    first_edge  = -1;
    second_edge = -1;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk_i);
      #1;
      if (data_valid_o) begin
        if (first_edge < 0) first_edge = i;
        else if (second_edge < 0) second_edge = i;
      end
    end
    enable_i = 1'b0;
    check("b2b_first", first_edge, 17);
    check("b2b_period", second_edge - first_edge, 19);
    check("b2b_q", {24'd0, quotient_o}, 32'h0000_000E);
    repeat (25) @(posedge clk_i);
    #1;
    check("b2b_idle", {31'd0, busy_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
